// File: rtl/rgbw_frame_dispatcher_pkg.sv
// Shared definitions for the RGBW SPI frame dispatcher and its consumers:
// FSM encoding, default sync marker and channel slot assignments.
package rgbw_frame_dispatcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_COMMIT  = 2'd3
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'h55;

    // Channel slots as seen by the colour generator.
    localparam int CH_LINT      = 0;
    localparam int CH_COLOR_IDX = 1;
    localparam int CH_R         = 2;
    localparam int CH_G         = 3;
    localparam int CH_B         = 4;
    localparam int CH_W         = 5;
    localparam int CH_MODE      = 6;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rgbw_frame_dispatcher_if.sv
// Byte stream in from the SPI slave and committed channel bus out to the
// colour/PWM stages.
interface rgbw_frame_dispatcher_if #(
    parameter int NUM_CH = 7,
    parameter int DATA_W = 8
);
    logic                       rdy;
    logic [DATA_W-1:0]          buffRx_spi;
    logic [NUM_CH*DATA_W-1:0]   ch_out;
    logic                       frame_valid;
    logic                       frame_err;
    logic [7:0]                 err_cnt;

    modport master (
        output rdy, buffRx_spi,
        input  ch_out, frame_valid, frame_err, err_cnt
    );

    modport slave (
        input  rdy, buffRx_spi,
        output ch_out, frame_valid, frame_err, err_cnt
    );
endinterface

// File: rtl/rgbw_frame_dispatcher_rdy_edge_sync.sv
// Two-flop synchroniser for the SPI byte-ready strobe with a rising-edge
// event output; both flops only advance when the clock enable is high.
module rgbw_rdy_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic rdy_i,
    output logic event_o
);
    logic rdy_latch_q;
    logic rdy_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_latch_q <= 1'b0;
            rdy_prev_q  <= 1'b0;
        end else if (en_i) begin
            rdy_latch_q <= rdy_i;
            rdy_prev_q  <= rdy_latch_q;
        end
    end

    // Qualified with the enable so the consumer sees one event per rdy edge.
    assign event_o = en_i & rdy_latch_q & ~rdy_prev_q;

endmodule

// File: rtl/rgbw_frame_dispatcher.sv
// Frame hunter/collector: syncs on a marker byte, gathers NUM_CH channels,
// optionally checks an XOR byte, and commits all channels in one edge.
//
//   state   | meaning
//   IDLE    | hunting for SYNC_BYTE, other bytes dropped
//   PAYLOAD | storing channel bytes into the shadow array
//   CHECK   | waiting for the XOR checksum byte
//   COMMIT  | shadow -> ch_out, frame_valid pulse
module rgbw_frame_dispatcher
    import rgbw_frame_dispatcher_pkg::*;
#(
    parameter int                NUM_CH    = 7,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(SYNC_BYTE_DEF),
    parameter bit                CHK_EN    = 1'b1,
    parameter int                TIMEOUT   = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_half,
    rgbw_frame_dispatcher_if.slave  bus
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
    localparam logic [TMO_W-1:0] TMO_INIT = TMO_W'(TIMEOUT - 1);

    logic                     en;
    logic                     byte_ev;
    logic [DATA_W-1:0]        rx_byte;

    state_e                   state_q;
    logic [IDX_W-1:0]         idx_q;
    logic [DATA_W-1:0]        chk_q;
    logic [TMO_W-1:0]         tmo_q;
    logic [DATA_W-1:0]        shadow_q [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] ch_out_q;
    logic                     frame_valid_q;
    logic                     frame_err_q;
    logic [7:0]               err_cnt_q;
    logic                     pend_q;
    logic [DATA_W-1:0]        pend_byte_q;

    logic                     idle_ev;
    logic [DATA_W-1:0]        idle_byte;

    assign en      = ~clk_half;
    assign rx_byte = bus.buffRx_spi;

    rgbw_rdy_edge_sync u_rdy_sync (
        .clk     (clk),
        .reset   (reset),
        .en_i    (en),
        .rdy_i   (bus.rdy),
        .event_o (byte_ev)
    );

    // A byte caught during COMMIT is replayed in the following IDLE cycle.
    assign idle_ev   = byte_ev | pend_q;
    assign idle_byte = pend_q ? pend_byte_q : rx_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            chk_q         <= '0;
            tmo_q         <= TMO_INIT;
            for (int k = 0; k < NUM_CH; k++) shadow_q[k] <= '0;
            ch_out_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_cnt_q     <= 8'h00;
            pend_q        <= 1'b0;
            pend_byte_q   <= '0;
        end else if (en) begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    pend_q <= 1'b0;
                    if (idle_ev && idle_byte == SYNC_BYTE) begin
                        state_q <= ST_PAYLOAD;
                        idx_q   <= '0;
                        chk_q   <= '0;
                        tmo_q   <= TMO_INIT;
                    end
                end
                ST_PAYLOAD: begin
                    if (byte_ev) begin
                        shadow_q[idx_q] <= rx_byte;
                        chk_q           <= chk_q ^ rx_byte;
                        tmo_q           <= TMO_INIT;
                        if (idx_q == IDX_LAST) begin
                            state_q <= CHK_EN ? ST_CHECK : ST_COMMIT;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (tmo_q == '0) begin
                        frame_err_q <= 1'b1;
                        err_cnt_q   <= sat_inc8(err_cnt_q);
                        state_q     <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (byte_ev) begin
                        if (rx_byte == chk_q) begin
                            state_q <= ST_COMMIT;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_cnt_q   <= sat_inc8(err_cnt_q);
                            state_q     <= ST_IDLE;
                        end
                    end else if (tmo_q == '0) begin
                        frame_err_q <= 1'b1;
                        err_cnt_q   <= sat_inc8(err_cnt_q);
                        state_q     <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
                end
                ST_COMMIT: begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        ch_out_q[k*DATA_W +: DATA_W] <= shadow_q[k];
                    end
                    frame_valid_q <= 1'b1;
                    state_q       <= ST_IDLE;
                    if (byte_ev) begin
                        pend_q      <= 1'b1;
                        pend_byte_q <= rx_byte;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ch_out      = ch_out_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_rgbw_frame_dispatcher.sv
// Scoreboard bench: a default 7-channel dispatcher with checksum and a
// 3-channel variant without checksum share clock, enable and reset.
module tb_rgbw_frame_dispatcher;
    import rgbw_frame_dispatcher_pkg::*;

    typedef struct packed {
        logic        is_err;
        logic [55:0] ch;
        logic [7:0]  ec;
    } exp_t;

    logic clk;
    logic clk_half;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    exp_t qa[$];
    exp_t qb[$];
    logic [55:0] last_ch;
    logic [7:0]  exp_ec;

    rgbw_frame_dispatcher_if #(.NUM_CH(7), .DATA_W(8)) ifa ();
    rgbw_frame_dispatcher_if #(.NUM_CH(3), .DATA_W(8)) ifb ();

    rgbw_frame_dispatcher #(.NUM_CH(7), .DATA_W(8), .CHK_EN(1'b1), .TIMEOUT(1024)) dut_a (
        .clk(clk), .reset(rst_n), .clk_half(clk_half), .bus(ifa)
    );

    rgbw_frame_dispatcher #(.NUM_CH(3), .DATA_W(8), .CHK_EN(1'b0), .TIMEOUT(1024)) dut_b (
        .clk(clk), .reset(rst_n), .clk_half(clk_half), .bus(ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        clk_half = 1'b0;
        forever @(negedge clk) clk_half = ~clk_half;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Output monitor: one pop per pulse rising edge, pulse width in clk cycles.
    logic a_prev = 1'b0, b_prev = 1'b0;
    int   a_w = 0, b_w = 0;
    initial begin
        exp_t e;
        logic a_now, b_now;
        forever begin
            @(negedge clk);
            a_now = ifa.frame_valid | ifa.frame_err;
            b_now = ifb.frame_valid | ifb.frame_err;
            if (a_now) check_val("a_excl", {63'd0, ifa.frame_valid & ifa.frame_err}, 64'd0);
            if (a_now && !a_prev) begin
                if (qa.size() == 0) check_val("a_unexpected", 64'd1, 64'd0);
                else begin
                    e = qa.pop_front();
                    check_val("a_kind", {63'd0, ifa.frame_err}, {63'd0, e.is_err});
                    check_val("a_ch", {8'd0, ifa.ch_out}, {8'd0, e.ch});
                    check_val("a_errcnt", {56'd0, ifa.err_cnt}, {56'd0, e.ec});
                end
            end
            if (a_now) a_w++;
            else if (a_prev) begin
                check_val("a_pulse_w", 64'(a_w), 64'd2);
                a_w = 0;
            end
            a_prev = a_now;

            if (b_now && !b_prev) begin
                if (qb.size() == 0) check_val("b_unexpected", 64'd1, 64'd0);
                else begin
                    e = qb.pop_front();
                    check_val("b_kind", {63'd0, ifb.frame_err}, {63'd0, e.is_err});
                    check_val("b_ch", {40'd0, ifb.ch_out}, {8'd0, e.ch});
                    check_val("b_errcnt", {56'd0, ifb.err_cnt}, {56'd0, e.ec});
                end
            end
            if (b_now) b_w++;
            else if (b_prev) begin
                check_val("b_pulse_w", 64'(b_w), 64'd2);
                b_w = 0;
            end
            b_prev = b_now;
        end
    end

    task automatic send_byte(input bit to_b, input logic [7:0] b, input int hi_clks);
        @(negedge clk);
        if (to_b) begin
            ifb.buffRx_spi = b;
            ifb.rdy        = 1'b1;
        end else begin
            ifa.buffRx_spi = b;
            ifa.rdy        = 1'b1;
        end
        repeat (hi_clks) @(negedge clk);
        ifa.rdy = 1'b0;
        ifb.rdy = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [7:0] sat_next(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    task automatic send_frame_a(input logic [55:0] pay, input bit bad);
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < 7; k++) x = x ^ pay[k*8 +: 8];
        if (bad) begin
            exp_ec = sat_next(exp_ec);
            qa.push_back('{1'b1, last_ch, exp_ec});
        end else begin
            last_ch = pay;
            qa.push_back('{1'b0, pay, exp_ec});
        end
        send_byte(1'b0, 8'h55, 4);
        for (int k = 0; k < 7; k++) send_byte(1'b0, pay[k*8 +: 8], 4);
        send_byte(1'b0, x ^ {7'd0, bad}, 4);
    endtask

    initial begin
        logic [63:0] r;
        ifa.rdy = 1'b0; ifa.buffRx_spi = 8'h00;
        ifb.rdy = 1'b0; ifb.buffRx_spi = 8'h00;
        last_ch = '0;
        exp_ec  = 8'h00;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_a_ch", {8'd0, ifa.ch_out}, 64'd0);
        check_val("rst_a_errcnt", {56'd0, ifa.err_cnt}, 64'd0);
        check_val("rst_a_pulses", {62'd0, ifa.frame_valid, ifa.frame_err}, 64'd0);
        check_val("rst_b_ch", {40'd0, ifb.ch_out}, 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Good frame, then the same payload with a corrupted checksum.
        send_frame_a(56'h03_40_00_80_FF_02_10, 1'b0);
        send_frame_a(56'h03_40_00_80_FF_02_10, 1'b1);

        // Junk byte, sync, then a sync-valued byte that must land in ch0.
        send_byte(1'b0, 8'hA0, 4);
        send_frame_a(56'h06_05_04_03_02_01_55, 1'b0);
        repeat (6) @(negedge clk);
        check_val("a_ch_lint", {56'd0, ifa.ch_out[CH_LINT*8 +: 8]}, 64'h55);
        check_val("a_ch_mode", {56'd0, ifa.ch_out[CH_MODE*8 +: 8]}, 64'h06);

        // Stall after three payload bytes.
        exp_ec = sat_next(exp_ec);
        qa.push_back('{1'b1, last_ch, exp_ec});
        send_byte(1'b0, 8'h55, 4);
        send_byte(1'b0, 8'hDE, 4);
        send_byte(1'b0, 8'hAD, 4);
        send_byte(1'b0, 8'hBE, 4);
        repeat (2200) @(negedge clk);
        check_val("a_tmo_drained", 64'(qa.size()), 64'd0);
        send_frame_a(56'h77_66_55_44_33_22_11, 1'b0);

        // Reset in the middle of a payload.
        send_byte(1'b0, 8'h55, 4);
        send_byte(1'b0, 8'h12, 4);
        send_byte(1'b0, 8'h34, 4);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("midrst_ch", {8'd0, ifa.ch_out}, 64'd0);
        check_val("midrst_errcnt", {56'd0, ifa.err_cnt}, 64'd0);
        check_val("midrst_pulses", {62'd0, ifa.frame_valid, ifa.frame_err}, 64'd0);
        last_ch = '0;
        exp_ec  = 8'h00;
        rst_n   = 1'b1;
        repeat (4) @(negedge clk);
        send_frame_a(56'hA1_B2_C3_D4_E5_F6_07, 1'b0);

        // Error counter saturation.
        for (int n = 0; n < 300; n++) begin
            r = {$urandom(), $urandom()};
            send_frame_a(r[55:0], 1'b1);
        end
        repeat (6) @(negedge clk);
        check_val("a_errcnt_sat", {56'd0, ifa.err_cnt}, 64'hFF);

        // Three-channel variant without checksum; second frame holds rdy long.
        qb.push_back('{1'b0, 56'h33_22_11, 8'h00});
        send_byte(1'b1, 8'h55, 4);
        send_byte(1'b1, 8'h11, 4);
        send_byte(1'b1, 8'h22, 4);
        send_byte(1'b1, 8'h33, 4);
        qb.push_back('{1'b0, 56'hCC_BB_AA, 8'h00});
        send_byte(1'b1, 8'h55, 4);
        send_byte(1'b1, 8'hAA, 10);
        send_byte(1'b1, 8'hBB, 4);
        send_byte(1'b1, 8'hCC, 4);

        repeat (20) @(negedge clk);
        check_val("a_drain", 64'(qa.size()), 64'd0);
        check_val("b_drain", 64'(qb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
